// File: rtl/network_bf_in_pkg.sv
// Shared types and constants for the NTT read-side crossbar.
// Bank-index type, lane-to-butterfly-port mapping, and delay-line word layout.
package network_bf_in_pkg;

    localparam int DATA_WIDTH = 12;
    localparam int NUM_LANES  = 4;
    localparam int BANK_W     = 2;

    typedef logic [BANK_W-1:0] bank_idx_t;

    localparam int LANE_BF0_UP = 0;
    localparam int LANE_BF0_LO = 1;
    localparam int LANE_BF1_UP = 2;
    localparam int LANE_BF1_LO = 3;

    // Delay-line word: {valid, sel_b_3, sel_b_2, sel_b_1, sel_b_0}
    localparam int SEL_VEC_W = 1 + NUM_LANES * BANK_W;
    localparam int VLD_BIT   = SEL_VEC_W - 1;

    function automatic int max_depth(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/network_bf_in_if.sv
// Bundle between the read scheduler / memory banks and the butterfly input crossbar.
interface network_bf_in_if #(
    parameter int data_width = network_bf_in_pkg::DATA_WIDTH
);
    import network_bf_in_pkg::*;

    logic                  sel;
    logic                  valid_in;
    bank_idx_t             sel_b_0;
    bank_idx_t             sel_b_1;
    bank_idx_t             sel_b_2;
    bank_idx_t             sel_b_3;
    logic [data_width-1:0] q0;
    logic [data_width-1:0] q1;
    logic [data_width-1:0] q2;
    logic [data_width-1:0] q3;
    logic [data_width-1:0] bf_0_upper;
    logic [data_width-1:0] bf_0_lower;
    logic [data_width-1:0] bf_1_upper;
    logic [data_width-1:0] bf_1_lower;
    logic                  valid_out;

    modport master (
        output sel, valid_in, sel_b_0, sel_b_1, sel_b_2, sel_b_3,
        output q0, q1, q2, q3,
        input  bf_0_upper, bf_0_lower, bf_1_upper, bf_1_lower, valid_out
    );

    modport slave (
        input  sel, valid_in, sel_b_0, sel_b_1, sel_b_2, sel_b_3,
        input  q0, q1, q2, q3,
        output bf_0_upper, bf_0_lower, bf_1_upper, bf_1_lower, valid_out
    );

endinterface

// File: rtl/shifter.sv
// Fixed-depth register delay line with asynchronous clear.
module shifter #(
    parameter int data_width = 9,
    parameter int depth      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] din,
    output logic [data_width-1:0] dout
);

    logic [data_width-1:0] stage [depth];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < depth; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < depth; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[depth-1];

endmodule

// File: rtl/network_bf_in.sv
// Read-side crossbar: routes bank words q0..q3 onto the two butterflies' inputs,
// with bank selects delayed to meet the returning read data of the active schedule.
module network_bf_in
    import network_bf_in_pkg::*;
#(
    parameter int data_width = DATA_WIDTH,
    parameter int depth_s    = 1,
    parameter int depth_i    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    network_bf_in_if.slave       bus
);

    localparam int GUARD_MAX = max_depth(depth_s, depth_i);
    localparam int GUARD_W   = $clog2(GUARD_MAX + 1);

    logic [SEL_VEC_W-1:0]  rd_sel_p0;
    logic [SEL_VEC_W-1:0]  rd_sel_s_p1;
    logic [SEL_VEC_W-1:0]  rd_sel_i_p1;
    logic [SEL_VEC_W-1:0]  rd_sel_p1;
    logic                  vld_p1;
    logic [data_width-1:0] lane_mux_p1 [NUM_LANES];

    logic                  sel_q;
    logic                  primed;
    logic [GUARD_W-1:0]    guard;
    logic [GUARD_W-1:0]    guard_nxt;

    function automatic logic [data_width-1:0] bank_mux(
        input bank_idx_t             b,
        input logic [data_width-1:0] d0,
        input logic [data_width-1:0] d1,
        input logic [data_width-1:0] d2,
        input logic [data_width-1:0] d3
    );
        case (b)
            2'd0:    return d0;
            2'd1:    return d1;
            2'd2:    return d2;
            default: return d3;
        endcase
    endfunction

    // ---- stage p0: read issue, selects enter both schedule delay lines ----
    assign rd_sel_p0 = {bus.valid_in, bus.sel_b_3, bus.sel_b_2, bus.sel_b_1, bus.sel_b_0};

    shifter #(.data_width(SEL_VEC_W), .depth(depth_s)) u_dly_ntt (
        .clk  (clk),
        .rst  (rst),
        .din  (rd_sel_p0),
        .dout (rd_sel_s_p1)
    );

    shifter #(.data_width(SEL_VEC_W), .depth(depth_i)) u_dly_intt (
        .clk  (clk),
        .rst  (rst),
        .din  (rd_sel_p0),
        .dout (rd_sel_i_p1)
    );

    // ---- stage p1: delayed selects meet bank data, combinational 4:1 per lane ----
    assign rd_sel_p1 = bus.sel ? rd_sel_i_p1 : rd_sel_s_p1;
    assign vld_p1    = rd_sel_p1[VLD_BIT];

    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_mux_p1[k] = bank_mux(bank_idx_t'(rd_sel_p1[BANK_W*k +: BANK_W]),
                                      bus.q0, bus.q1, bus.q2, bus.q3);
        end
    end

    // Guard uses the next counter value so blanking starts on the first output
    // after a toggle and lasts exactly GUARD_MAX cycles.
    always_comb begin
        guard_nxt = guard;
        if (bus.sel != sel_q) begin
            guard_nxt = GUARD_W'(GUARD_MAX);
        end else if (guard != '0) begin
            guard_nxt = guard - GUARD_W'(1);
        end
    end

    // ---- stage p2: registered butterfly operands ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q          <= 1'b0;
            guard          <= '0;
            primed         <= 1'b0;
            bus.valid_out  <= 1'b0;
            bus.bf_0_upper <= '0;
            bus.bf_0_lower <= '0;
            bus.bf_1_upper <= '0;
            bus.bf_1_lower <= '0;
        end else begin
            sel_q         <= bus.sel;
            guard         <= guard_nxt;
            primed        <= primed | vld_p1;
            bus.valid_out <= vld_p1 & (guard_nxt == '0);
            // Operands hold zero after reset until the first delayed read lands.
            if (primed || vld_p1) begin
                bus.bf_0_upper <= lane_mux_p1[LANE_BF0_UP];
                bus.bf_0_lower <= lane_mux_p1[LANE_BF0_LO];
                bus.bf_1_upper <= lane_mux_p1[LANE_BF1_UP];
                bus.bf_1_lower <= lane_mux_p1[LANE_BF1_LO];
            end
        end
    end

endmodule

// File: tb/tb_network_bf_in.sv
// Directed bench for the NTT read-side crossbar (depth_s=1, depth_i=2).
module tb_network_bf_in;
    import network_bf_in_pkg::*;

    localparam int DW = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    network_bf_in_if #(.data_width(DW)) bus ();

    network_bf_in #(.data_width(DW), .depth_s(1), .depth_i(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input int b0, input int b1, input int b2, input int b3);
        bus.valid_in = v;
        bus.sel_b_0  = bank_idx_t'(b0);
        bus.sel_b_1  = bank_idx_t'(b1);
        bus.sel_b_2  = bank_idx_t'(b2);
        bus.sel_b_3  = bank_idx_t'(b3);
    endtask

    task automatic set_q(input int a, input int b, input int c, input int d);
        bus.q0 = DW'(a);
        bus.q1 = DW'(b);
        bus.q2 = DW'(c);
        bus.q3 = DW'(d);
    endtask

    task automatic check_out(input string tag, input int e0, input int e1,
                             input int e2, input int e3, input int ev);
        check({tag, ".bf0u"}, int'(bus.bf_0_upper), e0);
        check({tag, ".bf0l"}, int'(bus.bf_0_lower), e1);
        check({tag, ".bf1u"}, int'(bus.bf_1_upper), e2);
        check({tag, ".bf1l"}, int'(bus.bf_1_lower), e3);
        check({tag, ".vld"},  int'(bus.valid_out),  ev);
    endtask

    initial begin
        rst     = 1'b1;
        bus.sel = 1'b0;
        issue(1'b0, 0, 0, 0, 0);
        set_q(int'($urandom_range(4095)), int'($urandom_range(4095)),
              int'($urandom_range(4095)), int'($urandom_range(4095)));
        tick();
        tick();

        // Reset state, then release with no reads: operands must stay zero.
        check_out("rst", 0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_q(int'($urandom_range(4095)), int'($urandom_range(4095)),
                  int'($urandom_range(4095)), int'($urandom_range(4095)));
            tick();
            check_out($sformatf("idle%0d", c), 0, 0, 0, 0, 0);
        end

        // NTT identity routing: data one cycle after issue, result one cycle later.
        issue(1'b1, 0, 1, 2, 3);
        tick();
        issue(1'b0, 0, 0, 0, 0);
        set_q('h111, 'h222, 'h333, 'h444);
        tick();
        check_out("ntt_id", 'h111, 'h222, 'h333, 'h444, 1);
        tick();
        check("ntt_bubble.vld", int'(bus.valid_out), 0);

        // INTT permuted routing: data two cycles after issue.
        bus.sel = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        issue(1'b1, 3, 2, 1, 0);
        tick();
        issue(1'b0, 0, 0, 0, 0);
        set_q('hF0F, 'hF0F, 'hF0F, 'hF0F);
        tick();
        set_q('h5A1, 'h5A2, 'h5A3, 'h5A4);
        tick();
        check_out("intt_perm", 'h5A4, 'h5A3, 'h5A2, 'h5A1, 1);

        // Broadcast of bank 2, eight back-to-back reads in NTT mode.
        bus.sel = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        set_q('hAAA, 'hBBB, 0, 'hCCC);
        for (int c = 0; c <= 10; c++) begin
            if (c >= 2 && c <= 9)
                check_out($sformatf("bcast%0d", c - 2), c - 2, c - 2, c - 2, c - 2, 1);
            if (c == 10)
                check("bcast_end.vld", int'(bus.valid_out), 0);
            issue(c < 8, 2, 2, 2, 2);
            if (c >= 1) bus.q2 = DW'(c - 1);
            tick();
        end
        issue(1'b0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) tick();

        // Continuous stream with rotating selects; switch NTT->INTT at cycle 4.
        for (int c = 0; c <= 9; c++) begin
            if (c >= 2 && c <= 4)
                check_out($sformatf("sw_ntt%0d", c), (c-1)*16 + (0+c-2)%4, (c-1)*16 + (1+c-2)%4,
                          (c-1)*16 + (2+c-2)%4, (c-1)*16 + (3+c-2)%4, 1);
            if (c == 5 || c == 6)
                check($sformatf("sw_guard%0d.vld", c), int'(bus.valid_out), 0);
            if (c >= 7)
                check_out($sformatf("sw_intt%0d", c), (c-1)*16 + (0+c-3)%4, (c-1)*16 + (1+c-3)%4,
                          (c-1)*16 + (2+c-3)%4, (c-1)*16 + (3+c-3)%4, 1);
            bus.sel = (c >= 4);
            issue(1'b1, (0+c)%4, (1+c)%4, (2+c)%4, (3+c)%4);
            set_q(c*16 + 0, c*16 + 1, c*16 + 2, c*16 + 3);
            tick();
        end
        issue(1'b0, 0, 0, 0, 0);

        // Asynchronous reset while reads are in flight.
        bus.sel = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        set_q('h321, 'h654, 'h987, 'hCBA);
        issue(1'b1, 1, 1, 1, 1);
        tick();
        issue(1'b1, 2, 2, 2, 2);
        #2;
        rst = 1'b1;
        #1;
        check_out("mid_rst", 0, 0, 0, 0, 0);
        tick();
        issue(1'b1, 3, 3, 3, 3);
        tick();
        rst = 1'b0;
        issue(1'b0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check_out($sformatf("post_rst%0d", c), 0, 0, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
